// File: rtl/smpte_pkg.sv
// Shared geometry, colour levels and enum types for the colour-bar generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package smpte_pkg;

    localparam int H_ACTIVE    = 1920;
    localparam int V_ACTIVE    = 1080;
    localparam int PILLAR_W    = 240;
    localparam int BAR_W       = 206;
    localparam int ROW1_END    = 630;
    localparam int ROW2_END    = 720;
    localparam int ROW3_END    = 810;
    localparam int RAMP_STEP   = 45;
    localparam int MARKER_W    = 16;
    localparam int MARKER_STEP = 4;

    // Largest marker offset that still keeps the marker inside the bar region.
    localparam int MARKER_MAX  = H_ACTIVE - 2 * PILLAR_W - MARKER_W;

    localparam logic [7:0] LVL_ZERO     = 8'd0;
    localparam logic [7:0] LVL_75       = 8'd191;
    localparam logic [7:0] LVL_GREY     = 8'd102;
    localparam logic [7:0] LVL_FULL     = 8'd255;
    localparam logic [7:0] LVL_PLUGE_LO = 8'd10;
    localparam logic [7:0] LVL_PLUGE_HI = 8'd20;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [3:0] {
        SEG0, SEG1, SEG2, SEG3, SEG4, SEG5, SEG6, SEG7, SEG8
    } seg_t;

    typedef enum logic [1:0] {
        BAND1, BAND2, BAND3, BAND4
    } band_t;

    function automatic rgb_t mk_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        rgb_t c;
        c.r = r;
        c.g = g;
        c.b = b;
        return c;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Generic N-stage delay line for a small bundle of control bits.
// Latency: exactly N clocks; each stage resets to RST_VAL.
// Backpressure: none, free-running every clock.
module sync_delay #(
    parameter int N = 2,
    parameter int W = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [N-1:0][W-1:0] stage_q;
    logic [N-1:0][W-1:0] stage_d;

    // Shift the bundle one stage further along each clock.
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers, cleared to the idle value on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {N{RST_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[N-1];

endmodule

// File: rtl/smpte_bars.sv
// SMPTE-style colour bars (pillars, bars, ramp, PLUGE, moving marker) from 1080p timing.
// Latency: 2 clocks; stage 1 = seg/band/ramp/marker, stage 2 = colour lookup; syncs delayed to match.
// Backpressure: none, one pixel accepted and produced every clock.
module smpte_bars
    import smpte_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic        ACTIVE,
    input  logic [12:0] h,
    input  logic [12:0] v,
    output logic [7:0]  R_O,
    output logic [7:0]  G_O,
    output logic [7:0]  B_O,
    output logic        HSYNC_O,
    output logic        VSYNC_O,
    output logic        DE_O
);

    localparam logic [12:0] H_SEG8 = 13'(H_ACTIVE - PILLAR_W);

    // Stage 1 state
    seg_t        seg_q, seg_d;
    logic [12:0] seg_cnt_q, seg_cnt_d;
    logic [15:0] acc_q, acc_d;
    logic [16:0] acc_sum;
    band_t       band_q, band_d;
    logic [7:0]  ramp_q, ramp_d;
    logic        marker_q, marker_d;
    logic        act_q, act_d;
    logic [12:0] marker_pos_q, marker_pos_d;
    logic [12:0] marker_next;
    logic [12:0] marker_lo;
    logic        vsync_prev_q, vsync_prev_d;

    // Stage 2 state
    rgb_t        lut;
    rgb_t        rgb_q, rgb_d;

    // Segment counter: realigns at h==0, forced to the right pillar, saturates at seg 8.
    always_comb begin
        seg_d     = seg_q;
        seg_cnt_d = seg_cnt_q;
        if (ACTIVE) begin
            if (h == 13'd0) begin
                seg_d     = SEG0;
                seg_cnt_d = 13'(PILLAR_W - 1);
            end else if (h == H_SEG8) begin
                seg_d     = SEG8;
                seg_cnt_d = 13'(PILLAR_W - 1);
            end else if (seg_cnt_q == 13'd0) begin
                if (seg_q != SEG8) begin
                    seg_d = seg_t'(seg_q + 4'd1);
                end
                seg_cnt_d = 13'(BAR_W - 1);
            end else begin
                seg_cnt_d = seg_cnt_q - 13'd1;
            end
        end
    end

    // Ramp accumulator: shows the value before this pixel's step, so the ramp starts at 0.
    always_comb begin
        acc_sum = {1'b0, acc_q} + 17'(RAMP_STEP);
        acc_d   = acc_q;
        ramp_d  = acc_q[15:8];
        if (ACTIVE) begin
            if (h == 13'd0) begin
                acc_d = 16'd0;
            end else if (seg_d != SEG0 && seg_d != SEG8) begin
                acc_d = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
            end
        end
    end

    // Band decode, marker hit test and marker advance on VSYNC falling edge.
    always_comb begin
        if (v < 13'(ROW1_END)) begin
            band_d = BAND1;
        end else if (v < 13'(ROW2_END)) begin
            band_d = BAND2;
        end else if (v < 13'(ROW3_END)) begin
            band_d = BAND3;
        end else begin
            band_d = BAND4;
        end

        act_d        = ACTIVE;
        vsync_prev_d = VSYNC;
        marker_lo    = 13'(PILLAR_W) + marker_pos_q;
        marker_d     = (h >= marker_lo) && (h < marker_lo + 13'(MARKER_W));

        marker_next  = marker_pos_q + 13'(MARKER_STEP);
        marker_pos_d = marker_pos_q;
        if (vsync_prev_q && !VSYNC) begin
            marker_pos_d = (marker_next > 13'(MARKER_MAX)) ? 13'd0 : marker_next;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_q        <= SEG0;
            seg_cnt_q    <= 13'(PILLAR_W - 1);
            acc_q        <= 16'd0;
            band_q       <= BAND1;
            ramp_q       <= 8'd0;
            marker_q     <= 1'b0;
            act_q        <= 1'b0;
            marker_pos_q <= 13'd0;
            vsync_prev_q <= 1'b1;
        end else begin
            seg_q        <= seg_d;
            seg_cnt_q    <= seg_cnt_d;
            acc_q        <= acc_d;
            band_q       <= band_d;
            ramp_q       <= ramp_d;
            marker_q     <= marker_d;
            act_q        <= act_d;
            marker_pos_q <= marker_pos_d;
            vsync_prev_q <= vsync_prev_d;
        end
    end

    // Colour lookup per band/segment; blanked whenever the pixel is outside active picture.
    always_comb begin
        lut = mk_rgb(LVL_ZERO, LVL_ZERO, LVL_ZERO);
        case (band_q)
            BAND1: begin
                case (seg_q)
                    SEG1:    lut = mk_rgb(LVL_75,   LVL_75,   LVL_75);
                    SEG2:    lut = mk_rgb(LVL_75,   LVL_75,   LVL_ZERO);
                    SEG3:    lut = mk_rgb(LVL_ZERO, LVL_75,   LVL_75);
                    SEG4:    lut = mk_rgb(LVL_ZERO, LVL_75,   LVL_ZERO);
                    SEG5:    lut = mk_rgb(LVL_75,   LVL_ZERO, LVL_75);
                    SEG6:    lut = mk_rgb(LVL_75,   LVL_ZERO, LVL_ZERO);
                    SEG7:    lut = mk_rgb(LVL_ZERO, LVL_ZERO, LVL_75);
                    default: lut = mk_rgb(LVL_GREY, LVL_GREY, LVL_GREY);
                endcase
            end
            BAND2: begin
                if (seg_q == SEG0) begin
                    lut = mk_rgb(LVL_ZERO, LVL_FULL, LVL_FULL);
                end else if (seg_q == SEG8) begin
                    lut = mk_rgb(LVL_ZERO, LVL_ZERO, LVL_FULL);
                end else begin
                    lut = mk_rgb(LVL_75, LVL_75, LVL_75);
                end
            end
            BAND3: begin
                if (seg_q == SEG0) begin
                    lut = mk_rgb(LVL_FULL, LVL_FULL, LVL_ZERO);
                end else if (seg_q == SEG8) begin
                    lut = mk_rgb(LVL_FULL, LVL_ZERO, LVL_ZERO);
                end else begin
                    lut = mk_rgb(ramp_q, ramp_q, ramp_q);
                end
            end
            default: begin
                if (marker_q) begin
                    lut = mk_rgb(LVL_FULL, LVL_FULL, LVL_FULL);
                end else if (seg_q == SEG5) begin
                    lut = mk_rgb(LVL_PLUGE_LO, LVL_PLUGE_LO, LVL_PLUGE_LO);
                end else if (seg_q == SEG6) begin
                    lut = mk_rgb(LVL_PLUGE_HI, LVL_PLUGE_HI, LVL_PLUGE_HI);
                end
            end
        endcase
        rgb_d = act_q ? lut : mk_rgb(LVL_ZERO, LVL_ZERO, LVL_ZERO);
    end

    // Stage 2 register: final RGB.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rgb_q <= mk_rgb(LVL_ZERO, LVL_ZERO, LVL_ZERO);
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign R_O = rgb_q.r;
    assign G_O = rgb_q.g;
    assign B_O = rgb_q.b;

    sync_delay #(
        .N       (2),
        .W       (3),
        .RST_VAL (3'b110)
    ) u_sync_delay (
        .clk   (CLK),
        .rst_n (RST_N),
        .din   ({HSYNC, VSYNC, ACTIVE}),
        .dout  ({HSYNC_O, VSYNC_O, DE_O})
    );

endmodule
